// File: rtl/spi_master_if.sv
// Bundle of the parallel command side and the serial SPI side of the master.
// Latency: none; this is a wiring container only.
// Backpressure: none; start is only honoured while the master is idle.
interface spi_master_if #(
  parameter int DATA_W = 8
);
  // Parallel command interface
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  // Serial bus
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;

  // The SPI master drives the bus and reports status
  modport master (
    input  start,
    input  tx_data,
    input  miso,
    output busy,
    output done,
    output rx_data,
    output cs,
    output sclk,
    output mosi
  );

  // The requester / attached slave side
  modport slave (
    output start,
    output tx_data,
    output miso,
    input  busy,
    input  done,
    input  rx_data,
    input  cs,
    input  sclk,
    input  mosi
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master: one DATA_W-bit full-duplex frame per start, MSB first.
// Latency: done pulses in the ((2*DATA_W+2)*CLK_DIV+1)-th cycle after the accepting edge.
// Backpressure: start is ignored while a frame is in flight (busy or DONE); nothing is queued.
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 8
) (
  input logic         clk,
  input logic         rst_n,
  spi_master_if.master bus
);

  // Refuse to elaborate with a divider that cannot give a 50% sclk
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be at least 2");
  end
  // The shift registers need at least two bits to shift through
  if (DATA_W < 2) begin : g_bad_data_w
    $error("spi_master: DATA_W must be at least 2");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // div_tick marks the last clk cycle of a half-period (or of the setup/hold windows)
  logic div_tick;
  // last_fall marks the half-period that ends in the final falling edge of the frame
  logic last_fall;

  assign div_tick  = (div_q == DIV_LAST);
  assign last_fall = sclk_q && (bit_q == BIT_LAST);

  // State and datapath registers; reset forces the bus idle and drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state: setup window, 2*DATA_W half-periods, hold window, one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETUP;
      SETUP:   if (div_tick) state_d = XFER;
      XFER:    if (div_tick && last_fall) state_d = HOLD;
      HOLD:    if (div_tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath: all bus outputs are registered so cs/sclk/mosi never glitch
  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Counters stay parked at zero until a frame is accepted
        div_d = '0;
        bit_d = '0;
        if (bus.start) begin
          tx_shift_d = bus.tx_data;
          rx_shift_d = '0;
          mosi_d     = bus.tx_data[DATA_W-1];
          cs_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      SETUP: begin
        // cs is already low; wait one half-period before the first rising edge
        div_d = div_tick ? '0 : div_q + DIV_ONE;
      end

      XFER: begin
        div_d = div_tick ? '0 : div_q + DIV_ONE;
        if (div_tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: capture miso as seen in this very cycle
            rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.miso};
          end else begin
            // Falling edge: count the bit; present the next one unless the frame is over
            bit_d = bit_q + BIT_ONE;
            if (!last_fall) begin
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
              mosi_d     = tx_shift_q[DATA_W-2];
            end
          end
        end
      end

      HOLD: begin
        // sclk is low and mosi frozen; keep cs low for the hold window, then close the frame
        div_d = div_tick ? '0 : div_q + DIV_ONE;
        if (div_tick) begin
          cs_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          rx_d   = rx_shift_q;
          mosi_d = 1'b0;
        end
      end

      DONE: begin
        // Single status cycle; start is deliberately not looked at here
        div_d = '0;
        bit_d = '0;
      end

      default: begin
        div_d = '0;
        bit_d = '0;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.cs      = cs_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;

  // sclk only ever runs inside a frame
  a_sclk_idle_low: assert property (@(posedge clk) disable iff (!rst_n) cs_q |-> !sclk_q);
  // done is a single-cycle pulse
  a_done_pulse:    assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
  // done is only seen with the bus released and the master free
  a_done_idle:     assert property (@(posedge clk) disable iff (!rst_n) done_q |-> (cs_q && !busy_q));
  // The bit counter never runs past a full frame
  a_bit_range:     assert property (@(posedge clk) disable iff (!rst_n) bit_q <= BIT_W'(DATA_W));

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=2 and CLK_DIV=4 instances side by side.
// Cycle numbering: cycle 1 is the clk cycle right after the edge that accepted start.
// All driving and sampling happens 1 time unit after a rising clk edge.
module tb_spi_master;

  logic clk;
  logic rst_n;

  int vectors = 0;
  int errors  = 0;

  spi_master_if #(.DATA_W(8)) bus2 ();
  spi_master_if #(.DATA_W(8)) bus4 ();

  spi_master #(.CLK_DIV(2), .DATA_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  spi_master #(.CLK_DIV(4), .DATA_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // miso source for the CLK_DIV=2 instance: 0 loopback, 1 tied high, 2 tied low, 3 slave model
  logic [1:0] miso_mode = 2'd0;
  logic [7:0] slv_load  = 8'h3C;
  logic [7:0] slv_sh    = 8'h00;
  logic [7:0] slv_rx    = 8'h00;
  logic       slv_miso;

  assign slv_miso  = slv_sh[7];
  assign bus2.miso = (miso_mode == 2'd0) ? bus2.mosi :
                     (miso_mode == 2'd1) ? 1'b1 :
                     (miso_mode == 2'd2) ? 1'b0 : slv_miso;
  assign bus4.miso = bus4.mosi;

  // Behavioural mode-0 slave: first bit out on cs fall, sample on sclk rise, shift on sclk fall
  always @(negedge bus2.cs) slv_sh = slv_load;
  always @(posedge bus2.sclk) if (!bus2.cs) slv_rx = {slv_rx[6:0], bus2.mosi};
  always @(negedge bus2.sclk) if (!bus2.cs) slv_sh = {slv_sh[6:0], 1'b0};

  // Bus monitor for the CLK_DIV=2 instance (event counters only; tests compare deltas)
  int       m2_rises = 0, m2_cs_toggle = 0, m2_mosi_bad = 0, m2_timing_bad = 0;
  int       m2_mosi_hi = 0, m2_done_cnt = 0, m2_age = 100, m2_since_rise = 100;
  logic [7:0] m2_rise_bits = 8'h00;
  logic     m2_p_sclk = 1'b0, m2_p_cs = 1'b1, m2_p_mosi = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus2.mosi !== m2_p_mosi) begin
        if (bus2.sclk) m2_mosi_bad++;
        if (m2_since_rise < 1) m2_timing_bad++;
        m2_age = 0;
      end else begin
        m2_age++;
      end
      if (bus2.sclk && !m2_p_sclk && !bus2.cs) begin
        m2_rises++;
        m2_rise_bits = {m2_rise_bits[6:0], bus2.mosi};
        if (m2_age < 2) m2_timing_bad++;
        m2_since_rise = 0;
      end else begin
        m2_since_rise++;
      end
      if ((bus2.sclk !== m2_p_sclk) && bus2.cs && m2_p_cs) m2_cs_toggle++;
      if (bus2.mosi) m2_mosi_hi++;
      if (bus2.done) m2_done_cnt++;
    end
    m2_p_sclk = bus2.sclk;
    m2_p_cs   = bus2.cs;
    m2_p_mosi = bus2.mosi;
  end

  // Bus monitor for the CLK_DIV=4 instance: phase lengths and cs-high gaps
  int   m4_rises = 0, m4_phase_bad = 0, m4_run = 0, m4_cs_hi_run = 0, m4_last_gap = 0;
  logic m4_after_fall = 1'b0, m4_p_sclk = 1'b0, m4_p_cs = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus4.cs) begin
        if (bus4.sclk !== m4_p_sclk) begin
          if (!bus4.sclk) begin
            if (m4_run != 4) m4_phase_bad++;
            m4_after_fall = 1'b1;
          end else begin
            if (m4_after_fall && m4_run != 4) m4_phase_bad++;
            m4_after_fall = 1'b0;
            m4_rises++;
          end
          m4_run = 1;
        end else begin
          m4_run++;
        end
      end
      if (bus4.cs) begin
        m4_cs_hi_run++;
        m4_after_fall = 1'b0;
      end else if (m4_p_cs) begin
        m4_last_gap  = m4_cs_hi_run;
        m4_cs_hi_run = 0;
      end
    end
    m4_p_sclk = bus4.sclk;
    m4_p_cs   = bus4.cs;
  end

  // Pulse start for one cycle on the chosen instance; returns in cycle 1 of the frame
  task automatic start_frame(input int which, input logic [7:0] tx);
    if (which == 2) begin bus2.tx_data = tx; bus2.start = 1'b1; end
    else            begin bus4.tx_data = tx; bus4.start = 1'b1; end
    @(posedge clk); #1;
    bus2.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  // Observe a frame from cycle 1 for up to budget cycles; optionally stop in the done cycle
  task automatic watch_frame(input int which, input int budget, input bit stop_at_done,
                             output int cyc, output int ndone, output int busy_low);
    logic d, b;
    cyc = -1; ndone = 0; busy_low = 0;
    for (int i = 1; i <= budget; i++) begin
      d = (which == 2) ? bus2.done : bus4.done;
      b = (which == 2) ? bus2.busy : bus4.busy;
      if (d) begin
        ndone++;
        if (cyc < 0) cyc = i;
      end
      if (cyc < 0 && !b) busy_low++;
      if (stop_at_done && cyc > 0) return;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    vectors++; if (bus2.cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", bus2.cs); end
    vectors++; if (bus2.sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus2.sclk); end
    vectors++; if (bus2.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus2.mosi); end
    vectors++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus2.busy); end
    vectors++; if (bus2.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus2.done); end
    vectors++; if (bus2.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", bus2.rx_data); end
  endtask

  task automatic test_loopback();
    int cyc, nd, bl, r0;
    miso_mode = 2'd0;
    r0 = m2_rises;
    start_frame(2, 8'hA5);
    watch_frame(2, 50, 1'b0, cyc, nd, bl);
    vectors++; if (cyc !== 37) begin errors++; $display("FAIL loop_latency: got %0d expected 37", cyc); end
    vectors++; if (nd !== 1) begin errors++; $display("FAIL loop_done_width: got %0d expected 1", nd); end
    vectors++; if (bus2.rx_data !== 8'hA5) begin errors++; $display("FAIL loop_rx: got %h expected a5", bus2.rx_data); end
    vectors++; if (m2_rises - r0 !== 8) begin errors++; $display("FAIL loop_rises: got %0d expected 8", m2_rises - r0); end
    vectors++; if (bl !== 0) begin errors++; $display("FAIL loop_busy: got %0d low cycles expected 0", bl); end
  endtask

  task automatic test_tied_miso();
    int cyc, nd, bl, h0;
    miso_mode = 2'd1;
    h0 = m2_mosi_hi;
    start_frame(2, 8'h00);
    watch_frame(2, 45, 1'b0, cyc, nd, bl);
    vectors++; if (bus2.rx_data !== 8'hFF) begin errors++; $display("FAIL tie1_rx: got %h expected ff", bus2.rx_data); end
    vectors++; if (m2_mosi_hi - h0 !== 0) begin errors++; $display("FAIL tie1_mosi_low: got %0d high samples expected 0", m2_mosi_hi - h0); end
    miso_mode = 2'd2;
    start_frame(2, 8'hFF);
    watch_frame(2, 45, 1'b0, cyc, nd, bl);
    vectors++; if (bus2.rx_data !== 8'h00) begin errors++; $display("FAIL tie0_rx: got %h expected 00", bus2.rx_data); end
    vectors++; if (m2_rise_bits !== 8'hFF) begin errors++; $display("FAIL tie0_mosi_bits: got %h expected ff", m2_rise_bits); end
    vectors++; if (cyc !== 37) begin errors++; $display("FAIL tie0_latency: got %0d expected 37", cyc); end
  endtask

  task automatic test_slave();
    int cyc, nd, bl, mb0, ct0, tb0;
    miso_mode = 2'd3;
    slv_load  = 8'h3C;
    mb0 = m2_mosi_bad; ct0 = m2_cs_toggle; tb0 = m2_timing_bad;
    start_frame(2, 8'hC3);
    watch_frame(2, 45, 1'b0, cyc, nd, bl);
    vectors++; if (bus2.rx_data !== 8'h3C) begin errors++; $display("FAIL slave_master_rx: got %h expected 3c", bus2.rx_data); end
    vectors++; if (slv_rx !== 8'hC3) begin errors++; $display("FAIL slave_capture: got %h expected c3", slv_rx); end
    vectors++; if (m2_mosi_bad - mb0 !== 0) begin errors++; $display("FAIL slave_mosi_sclk_high: got %0d expected 0", m2_mosi_bad - mb0); end
    vectors++; if (m2_cs_toggle - ct0 !== 0) begin errors++; $display("FAIL slave_sclk_cs_high: got %0d expected 0", m2_cs_toggle - ct0); end
    vectors++; if (m2_timing_bad - tb0 !== 0) begin errors++; $display("FAIL slave_mosi_stable: got %0d expected 0", m2_timing_bad - tb0); end
    vectors++; if (bus2.sclk !== 1'b0) begin errors++; $display("FAIL slave_sclk_idle: got %b expected 0", bus2.sclk); end
  endtask

  task automatic test_start_while_busy();
    int cyc = -1, nd = 0, bl = 0;
    miso_mode = 2'd0;
    start_frame(2, 8'h5A);
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin bus2.start = 1'b1; bus2.tx_data = 8'h11; end
      if (i == 6) bus2.start = 1'b0;
      if (bus2.done) begin nd++; if (cyc < 0) cyc = i; end
      if (cyc < 0 && !bus2.busy) bl++;
      @(posedge clk); #1;
    end
    vectors++; if (nd !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", nd); end
    vectors++; if (cyc !== 37) begin errors++; $display("FAIL busy_latency: got %0d expected 37", cyc); end
    vectors++; if (bus2.rx_data !== 8'h5A) begin errors++; $display("FAIL busy_rx: got %h expected 5a", bus2.rx_data); end
    vectors++; if (bl !== 0) begin errors++; $display("FAIL busy_continuous: got %0d low cycles expected 0", bl); end
  endtask

  task automatic test_reset_mid_frame();
    int cyc, nd, bl, d0;
    miso_mode = 2'd0;
    d0 = m2_done_cnt;
    start_frame(2, 8'h96);
    repeat (9) begin @(posedge clk); #1; end
    vectors++; if (bus2.sclk !== 1'b1) begin errors++; $display("FAIL rst_mid_sclk_before: got %b expected 1", bus2.sclk); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus2.cs !== 1'b1) begin errors++; $display("FAIL rst_async_cs: got %b expected 1", bus2.cs); end
    vectors++; if (bus2.sclk !== 1'b0) begin errors++; $display("FAIL rst_async_sclk: got %b expected 0", bus2.sclk); end
    vectors++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", bus2.busy); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    vectors++; if (m2_done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", m2_done_cnt - d0); end
    vectors++; if (bus2.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_cleared: got %h expected 00", bus2.rx_data); end
    start_frame(2, 8'h69);
    watch_frame(2, 45, 1'b0, cyc, nd, bl);
    vectors++; if (cyc !== 37) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 37", cyc); end
    vectors++; if (bus2.rx_data !== 8'h69) begin errors++; $display("FAIL rst_fresh_rx: got %h expected 69", bus2.rx_data); end
  endtask

  task automatic test_back_to_back();
    int cyc, nd, bl, r0, p0;
    r0 = m4_rises; p0 = m4_phase_bad;
    start_frame(4, 8'h01);
    watch_frame(4, 100, 1'b1, cyc, nd, bl);
    vectors++; if (cyc !== 73) begin errors++; $display("FAIL b2b_latency1: got %0d expected 73", cyc); end
    vectors++; if (bus4.rx_data !== 8'h01) begin errors++; $display("FAIL b2b_rx1: got %h expected 01", bus4.rx_data); end
    @(posedge clk); #1;
    start_frame(4, 8'h80);
    vectors++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", bus4.busy); end
    vectors++; if (m4_last_gap < 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected at least 1", m4_last_gap); end
    watch_frame(4, 90, 1'b0, cyc, nd, bl);
    vectors++; if (cyc !== 73) begin errors++; $display("FAIL b2b_latency2: got %0d expected 73", cyc); end
    vectors++; if (bus4.rx_data !== 8'h80) begin errors++; $display("FAIL b2b_rx2: got %h expected 80", bus4.rx_data); end
    vectors++; if (m4_phase_bad - p0 !== 0) begin errors++; $display("FAIL b2b_phase_len: got %0d bad phases expected 0", m4_phase_bad - p0); end
    vectors++; if (m4_rises - r0 !== 16) begin errors++; $display("FAIL b2b_rises: got %0d expected 16", m4_rises - r0); end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus2.start   = 1'b0;
    bus2.tx_data = 8'h00;
    bus4.start   = 1'b0;
    bus4.tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_loopback();
    test_tied_miso();
    test_slave();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
